// File: rtl/mem_if_pkg.sv
// mem_if_pkg
//   Shared constants and types for the 128-bit block memory interface used
//   between the caches and the memory-side responder.
//   MEM_ADDR_W : line address width (byte address >> 4)
//   MEM_LINE_W : line width in bits
//   CNT_W      : width of the responder latency counter
//   mem_state_e: responder FSM states
package mem_if_pkg;

    localparam int MEM_ADDR_W = 28;
    localparam int MEM_LINE_W = 128;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/line_ram.sv
// line_ram
//   DEPTH x W single-port line storage. Synchronous write, synchronous read
//   with read enable; the read register holds its value when re is low.
//   Storage itself is not reset; only the read register is.
//   clk, rst_n : clock, async active-low reset (read register only)
//   we, re     : write / read enable (never both in one cycle)
//   addr       : line index
//   wdata      : write data
//   rdata      : registered read data
module line_ram #(
    parameter int DEPTH  = 256,
    parameter int W      = 128,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [W-1:0]      wdata,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_block_responder.sv
// mem_block_responder
//   Memory-side responder for the cache block interface. Accepts one block
//   read or write, waits LATENCY cycles, completes with a one-cycle mem_ready.
//   clk, rst_n : clock, async active-low reset
//   mem_read   : block read request, held until mem_ready
//   mem_write  : block write request, held until mem_ready
//   mem_addr   : line address; only the low log2(DEPTH) bits index storage
//   mem_wdata  : write line data
//   mem_rdata  : registered read data, holds between responses
//   mem_ready  : completion pulse
//   proto_err  : sticky protocol error (both requests high, or request
//                dropped before completion)
//
//   state | meaning
//   IDLE  | waiting for a request; accepts in the cycle it is seen
//   BUSY  | latency countdown on captured request; abort if request drops
//   RESP  | mem_ready high; read data valid / write commits at cycle end
import mem_if_pkg::*;

module mem_block_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [MEM_LINE_W-1:0] mem_wdata,
    output logic [MEM_LINE_W-1:0] mem_rdata,
    output logic                  mem_ready,
    output logic                  proto_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam bit SINGLE_CYCLE = (LATENCY == 1);

    mem_state_e            state;
    mem_state_e            state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic                  op_wr;
    logic [IDX_W-1:0]      idx;
    logic [MEM_LINE_W-1:0] wdata_q;

    logic                  accept;
    logic                  req_held;
    logic                  ram_we;
    logic                  ram_re;
    logic [IDX_W-1:0]      ram_addr;

    // Upper address bits alias onto the same lines by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[MEM_ADDR_W-1:IDX_W];

    assign accept   = (state == IDLE) && (mem_read || mem_write);
    assign req_held = op_wr ? mem_write : mem_read;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SINGLE_CYCLE ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (!req_held) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_wr     <= 1'b0;
            idx       <= '0;
            wdata_q   <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_wr   <= mem_write;
                        idx     <= mem_addr[IDX_W-1:0];
                        wdata_q <= mem_wdata;
                        cnt     <= CNT_LOAD;
                        if (mem_read && mem_write) begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (!req_held) begin
                        proto_err <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // The read is issued in the cycle before RESP so the RAM's read register
    // presents the line during RESP. With LATENCY==1 that cycle is the accept
    // cycle itself, so the index comes straight from mem_addr. A read whose
    // request drops in the last BUSY cycle is aborted, so it must not
    // disturb mem_rdata either.
    assign ram_addr = (state == IDLE) ? mem_addr[IDX_W-1:0] : idx;
    assign ram_re   = (SINGLE_CYCLE && (state == IDLE) && mem_read && !mem_write)
                    || ((state == BUSY) && (cnt == CNT_W'(1)) && !op_wr && mem_read);
    assign ram_we   = (state == RESP) && op_wr;

    line_ram #(
        .DEPTH  (DEPTH),
        .W      (MEM_LINE_W),
        .ADDR_W (IDX_W)
    ) u_line_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    assign mem_ready = (state == RESP);

endmodule
